// File: rtl/load_pkg.sv
// Shared types and constants for the load path: load opcodes, sequencer states
// and field widths, plus the size/alignment legality check.
package load_pkg;

   localparam int XLEN     = 64;
   localparam int ADDR_W   = 64;

   localparam int BYTE_W   = 8;
   localparam int HALF_W   = 16;
   localparam int WORD_W   = 32;
   localparam int DOUBLE_W = 64;

   typedef enum logic [2:0] {
      OP_LB      = 3'b000,
      OP_LH      = 3'b001,
      OP_LW      = 3'b010,
      OP_LD      = 3'b011,
      OP_LBU     = 3'b100,
      OP_LHU     = 3'b101,
      OP_LWU     = 3'b110,
      OP_ILLEGAL = 3'b111
   } load_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10
   } load_state_e;

   // A load is legal when the opcode is defined and the address is naturally aligned to its size.
   function automatic logic loadAccessOk(input load_op_e op, input logic [2:0] addrLo);
      logic ok;
      case (op)
         OP_LB, OP_LBU: ok = 1'b1;
         OP_LH, OP_LHU: ok = ~addrLo[0];
         OP_LW, OP_LWU: ok = (addrLo[1:0] == 2'b00);
         OP_LD:         ok = (addrLo == 3'b000);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_unit_if.sv
// Read channel between the load sequencer and the data memory port:
// valid/ready request with an aligned address, and a one-cycle response.
interface load_unit_if;
   import load_pkg::*;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rsp_data;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data
   );

endinterface

// File: rtl/load_align.sv
// Combinational load extraction: shifts the addressed field of an aligned
// doubleword down to bit 0, truncates it to the load size and extends it.
module load_align
   import load_pkg::*;
(
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      offset_i,
   input  load_op_e        op_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] shifted;

   // Byte offset becomes a bit shift; the field then sits at bit 0 for every size.
   always_comb begin
      shifted  = data_i >> {offset_i, 3'b000};
      result_o = '0;
      case (op_i)
         OP_LB:   result_o = {{(XLEN-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
         OP_LH:   result_o = {{(XLEN-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
         OP_LW:   result_o = {{(XLEN-WORD_W){shifted[WORD_W-1]}}, shifted[WORD_W-1:0]};
         OP_LD:   result_o = shifted[DOUBLE_W-1:0];
         OP_LBU:  result_o = {{(XLEN-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
         OP_LHU:  result_o = {{(XLEN-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
         OP_LWU:  result_o = {{(XLEN-WORD_W){1'b0}}, shifted[WORD_W-1:0]};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multicycle load sequencer: validates a load, issues one aligned doubleword
// read, waits for the response and presents the extended result with a strobe.
module load_unit
   import load_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        funct3,
   output logic              busy,
   load_unit_if.master       mem,
   output logic              load,
   output logic [XLEN-1:0]   r_data,
   output logic              fault
);

   load_state_e       state_q, state_d;
   logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
   logic [2:0]        offset_q, offset_d;
   load_op_e          op_q, op_d;
   logic [XLEN-1:0]   rData_q, rData_d;
   logic              load_q, load_d;
   logic              fault_q, fault_d;

   load_op_e          startOp;
   logic [XLEN-1:0]   alignedData;

   assign startOp = load_op_e'(funct3);

   load_align u_align (
      .data_i   (mem.mem_rsp_data),
      .offset_i (offset_q),
      .op_i     (op_q),
      .result_o (alignedData)
   );

   // State register and registered outputs; reset drops any in-flight load silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         reqAddr_q <= '0;
         offset_q  <= '0;
         op_q      <= OP_LB;
         rData_q   <= '0;
         load_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         reqAddr_q <= reqAddr_d;
         offset_q  <= offset_d;
         op_q      <= op_d;
         rData_q   <= rData_d;
         load_q    <= load_d;
         fault_q   <= fault_d;
      end
   end

   // Responses are only consumed in WAIT, so stale or early ones are dropped.
   always_comb begin
      state_d   = state_q;
      reqAddr_d = reqAddr_q;
      offset_d  = offset_q;
      op_d      = op_q;
      rData_d   = rData_q;
      load_d    = 1'b0;
      fault_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (loadAccessOk(startOp, addr[2:0])) begin
                  state_d   = S_REQ;
                  reqAddr_d = {addr[ADDR_W-1:3], 3'b000};
                  offset_d  = addr[2:0];
                  op_d      = startOp;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem.mem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.mem_rsp_valid) begin
               rData_d = alignedData;
               load_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy              = (state_q != S_IDLE);
   assign mem.mem_req_valid = (state_q == S_REQ);
   assign mem.mem_req_addr  = reqAddr_q;
   assign load              = load_q;
   assign r_data            = rData_q;
   assign fault             = fault_q;

endmodule
